// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg (package)
// Description : Shared definitions for the PC select unit: FSM state encoding,
//               exception cause codes, default vector base address and a
//               helper that sizes the source-select field.
// Contents    : pc_state_t, EXC_* codes, VEC_BASE_DEFAULT, sel_width()
// Options     : PC_ALIGN_CHECK_EN (used by pc_select_unit) raises EXC_MISALIGNED
//               on a load of a target whose low two bits are non-zero.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    // PC sequencer states. RUN is the only non-busy state.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_VEC_REQ  = 2'd1,
        ST_VEC_WAIT = 2'd2,
        ST_VEC_LOAD = 2'd3
    } pc_state_t;

    // Exception cause codes; each selects one byte of the vector table.
    localparam logic [1:0] EXC_OVERFLOW   = 2'd0;
    localparam logic [1:0] EXC_OPCODE     = 2'd1;
    localparam logic [1:0] EXC_DIV_ZERO   = 2'd2;
    localparam logic [1:0] EXC_MISALIGNED = 2'd3;

    // Address of the first vector-table byte.
    localparam int VEC_BASE_DEFAULT = 253;

    // Width of a select field for nsrc sources, never narrower than one bit.
    function automatic int sel_width(input int nsrc);
        return (nsrc > 1) ? $clog2(nsrc) : 1;
    endfunction

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_src_mux.sv
`default_nettype none
// ============================================================================
// Module      : pc_src_mux
// Description : NSRC:1 next-PC source multiplexer. Source i occupies
//               src_flat[i*WIDTH +: WIDTH]. A select value with no matching
//               source (possible when NSRC is not a power of two) yields zero.
// Ports       : sel      - source select (SEL_W bits)
//               src_flat - concatenated source buses (NSRC*WIDTH bits)
//               target   - selected source, or all-zero when out of range
// Revision    : 1.0 - initial release
// ============================================================================
module pc_src_mux #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 5,
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]      sel,
    input  logic [NSRC*WIDTH-1:0] src_flat,
    output logic [WIDTH-1:0]      target
);

    // Priority-free one-hot match: at most one index can equal sel, so the
    // loop reduces to a plain mux with a zero default.
    always_comb begin
        target = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (sel == SEL_W'(i)) begin
                target = src_flat[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule : pc_src_mux
`default_nettype wire

// File: rtl/pc_select_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_select_unit
// Description : Program-counter register with next-PC source selection,
//               unconditional/conditional load and a four-state exception
//               vector sequence (RUN -> VEC_REQ -> VEC_WAIT -> VEC_LOAD -> RUN).
//               On exception entry the current PC is saved in epc, a one-cycle
//               byte read is issued at VEC_BASE + cause, and the returned byte
//               (zero-extended) becomes the new PC.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               sel, src_flat         - next-PC source select / source buses
//               pc_write              - unconditional PC load
//               pc_write_cond, cond   - conditional PC load and its condition
//               exc_req, exc_code     - exception request and cause
//               mem_data              - vector byte returned by memory
//               pc, epc               - current PC, saved exception PC
//               vec_addr, vec_rd      - vector fetch address / read strobe
//               busy                  - high in every state but RUN
//               exc_taken             - one-cycle pulse while in VEC_LOAD
// Options     : PC_ALIGN_CHECK_EN - when defined, a load of a target with
//               non-zero bits [1:0] is converted into a misaligned exception.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_select_unit
    import pc_pkg::*;
#(
    parameter int              WIDTH     = 32,
    parameter int              NSRC      = 5,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] VEC_BASE  = WIDTH'(VEC_BASE_DEFAULT),
    localparam int             SEL_W     = sel_width(NSRC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SEL_W-1:0]      sel,
    input  logic [NSRC*WIDTH-1:0] src_flat,
    input  logic                  pc_write,
    input  logic                  pc_write_cond,
    input  logic                  cond,
    input  logic                  exc_req,
    input  logic [1:0]            exc_code,
    input  logic [7:0]            mem_data,
    output logic [WIDTH-1:0]      pc,
    output logic [WIDTH-1:0]      epc,
    output logic [WIDTH-1:0]      vec_addr,
    output logic                  vec_rd,
    output logic                  busy,
    output logic                  exc_taken
);

    pc_state_t        r_state;
    logic [WIDTH-1:0] w_target;
    logic             w_load;
    logic             w_exc_enter;
    logic [1:0]       w_exc_cause;
    logic             w_pc_update;

    pc_src_mux #(
        .WIDTH (WIDTH),
        .NSRC  (NSRC),
        .SEL_W (SEL_W)
    ) u_src_mux (
        .sel      (sel),
        .src_flat (src_flat),
        .target   (w_target)
    );

    // Decode of the RUN-state request. An external exception always wins
    // over a load; with alignment checking a misaligned load becomes an
    // exception of its own and never reaches the PC.
    always_comb begin
        w_load      = pc_write | (pc_write_cond & cond);
        w_exc_enter = 1'b0;
        w_exc_cause = exc_code;
        w_pc_update = 1'b0;
        if (exc_req) begin
            w_exc_enter = 1'b1;
        end else if (w_load) begin
`ifdef PC_ALIGN_CHECK_EN
            if (w_target[1:0] != 2'b00) begin
                w_exc_enter = 1'b1;
                w_exc_cause = EXC_MISALIGNED;
            end else begin
                w_pc_update = 1'b1;
            end
`else
            w_pc_update = 1'b1;
`endif
        end
    end

    // Single sequencer process; every output is registered. The vector
    // address register captures VEC_BASE + cause on entry, so it doubles as
    // the latched exception cause for the fetch cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_RUN;
            pc        <= RESET_VEC;
            epc       <= '0;
            vec_addr  <= '0;
            vec_rd    <= 1'b0;
            busy      <= 1'b0;
            exc_taken <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    exc_taken <= 1'b0;
                    if (w_exc_enter) begin
                        epc      <= pc;
                        vec_addr <= VEC_BASE + WIDTH'(w_exc_cause);
                        vec_rd   <= 1'b1;
                        busy     <= 1'b1;
                        r_state  <= ST_VEC_REQ;
                    end else begin
                        vec_addr <= '0;
                        vec_rd   <= 1'b0;
                        busy     <= 1'b0;
                        if (w_pc_update) begin
                            pc <= w_target;
                        end
                    end
                end
                ST_VEC_REQ: begin
                    // Read strobe lasts exactly one cycle; address returns
                    // to zero with it.
                    vec_rd   <= 1'b0;
                    vec_addr <= '0;
                    r_state  <= ST_VEC_WAIT;
                end
                ST_VEC_WAIT: begin
                    exc_taken <= 1'b1;
                    r_state   <= ST_VEC_LOAD;
                end
                ST_VEC_LOAD: begin
                    pc        <= WIDTH'(mem_data);
                    exc_taken <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= ST_RUN;
                end
                default: begin
                    vec_rd    <= 1'b0;
                    vec_addr  <= '0;
                    exc_taken <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= ST_RUN;
                end
            endcase
        end
    end

endmodule : pc_select_unit
`default_nettype wire

// File: tb/tb_pc_select_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_select_unit
// Description : Self-checking bench for pc_select_unit. Expected PC values
//               are queued as stimulus is applied and compared once the DUT
//               has had its clock edge. Expectations for the misaligned-load
//               scenario follow PC_ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_select_unit;

    localparam int          WIDTH   = 32;
    localparam int          NSRC    = 5;
    localparam int          SEL_W   = 3;
    localparam logic [31:0] RST_VEC = 32'h0000_0200;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [SEL_W-1:0]      sel;
    logic [NSRC*WIDTH-1:0] src_flat;
    logic                  pc_write, pc_write_cond, cond, exc_req;
    logic [1:0]            exc_code;
    logic [7:0]            mem_data;
    logic [WIDTH-1:0]      pc, epc, vec_addr;
    logic                  vec_rd, busy, exc_taken;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_pc;

    pc_select_unit #(
        .WIDTH     (WIDTH),
        .NSRC      (NSRC),
        .RESET_VEC (RST_VEC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sel           (sel),
        .src_flat      (src_flat),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .cond          (cond),
        .exc_req       (exc_req),
        .exc_code      (exc_code),
        .mem_data      (mem_data),
        .pc            (pc),
        .epc           (epc),
        .vec_addr      (vec_addr),
        .vec_rd        (vec_rd),
        .busy          (busy),
        .exc_taken     (exc_taken)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance one rising edge and settle; all sampling happens here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int idx, input logic [WIDTH-1:0] val);
        src_flat[idx*WIDTH +: WIDTH] = val;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (pc !== RST_VEC) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, RST_VEC); end
        checks++; if (epc !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h want 0", epc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (vec_rd !== 1'b0) begin errors++; $display("FAIL reset_vec_rd: got %b want 0", vec_rd); end
        checks++; if (vec_addr !== 32'h0) begin errors++; $display("FAIL reset_vec_addr: got %h want 0", vec_addr); end
        checks++; if (exc_taken !== 1'b0) begin errors++; $display("FAIL reset_exc_taken: got %b want 0", exc_taken); end
    endtask

    task automatic test_sel_load();
        sel = 3'd2; set_src(2, 32'h0000_0040); pc_write = 1'b1;
        #1;
        checks++; if (pc !== RST_VEC) begin errors++; $display("FAIL load_before_edge: got %h want %h", pc, RST_VEC); end
        exp_q.push_back(32'h0000_0040);
        tick();
        pc_write = 1'b0;
        exp_pc = exp_q.pop_front();
        checks++; if (pc !== exp_pc) begin errors++; $display("FAIL sel_load: got %h want %h", pc, exp_pc); end
    endtask

    task automatic test_cond_load();
        pc_write_cond = 1'b1; cond = 1'b0; sel = 3'd1; set_src(1, 32'h0000_0080);
        exp_q.push_back(32'h0000_0040);
        tick();
        exp_pc = exp_q.pop_front();
        checks++; if (pc !== exp_pc) begin errors++; $display("FAIL cond_false: got %h want %h", pc, exp_pc); end
        cond = 1'b1;
        exp_q.push_back(32'h0000_0080);
        tick();
        pc_write_cond = 1'b0; cond = 1'b0;
        exp_pc = exp_q.pop_front();
        checks++; if (pc !== exp_pc) begin errors++; $display("FAIL cond_true: got %h want %h", pc, exp_pc); end
    endtask

    task automatic test_exception();
        sel = 3'd3; set_src(3, 32'h0000_0100); pc_write = 1'b1;
        tick();
        // Exception with a simultaneous load: load must be ignored.
        sel = 3'd2; exc_req = 1'b1; exc_code = 2'd1;
        tick();
        exc_req = 1'b0;
        checks++; if (epc !== 32'h100) begin errors++; $display("FAIL exc_epc: got %h want 100", epc); end
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL exc_pc_hold: got %h want 100", pc); end
        checks++; if (vec_rd !== 1'b1) begin errors++; $display("FAIL exc_vec_rd: got %b want 1", vec_rd); end
        checks++; if (vec_addr !== 32'd254) begin errors++; $display("FAIL exc_vec_addr: got %0d want 254", vec_addr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL exc_busy1: got %b want 1", busy); end
        // pc_write stays asserted through the busy window and must be ignored.
        exc_req = 1'b1; exc_code = 2'd2;
        tick();
        exc_req = 1'b0;
        mem_data = 8'h24;
        checks++; if (vec_rd !== 1'b0) begin errors++; $display("FAIL wait_vec_rd: got %b want 0", vec_rd); end
        checks++; if (vec_addr !== 32'h0) begin errors++; $display("FAIL wait_vec_addr: got %h want 0", vec_addr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL exc_busy2: got %b want 1", busy); end
        checks++; if (exc_taken !== 1'b0) begin errors++; $display("FAIL wait_exc_taken: got %b want 0", exc_taken); end
        tick();
        pc_write = 1'b0;
        checks++; if (exc_taken !== 1'b1) begin errors++; $display("FAIL load_exc_taken: got %b want 1", exc_taken); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL exc_busy3: got %b want 1", busy); end
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL load_pc_hold: got %h want 100", pc); end
        exp_q.push_back(32'h0000_0024);
        tick();
        exp_pc = exp_q.pop_front();
        checks++; if (pc !== exp_pc) begin errors++; $display("FAIL vec_pc: got %h want %h", pc, exp_pc); end
        checks++; if (exc_taken !== 1'b0) begin errors++; $display("FAIL exc_taken_end: got %b want 0", exc_taken); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_end: got %b want 0", busy); end
        checks++; if (epc !== 32'h100) begin errors++; $display("FAIL epc_kept: got %h want 100", epc); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL no_retrigger: got %b want 0", busy); end
    endtask

    task automatic test_out_of_range();
        sel = 3'd4; set_src(4, 32'h0000_ABC0); pc_write = 1'b1;
        exp_q.push_back(32'h0000_ABC0);
        tick();
        exp_pc = exp_q.pop_front();
        checks++; if (pc !== exp_pc) begin errors++; $display("FAIL sel_last: got %h want %h", pc, exp_pc); end
        sel = 3'd7;
        exp_q.push_back(32'h0);
        tick();
        pc_write = 1'b0;
        exp_pc = exp_q.pop_front();
        checks++; if (pc !== exp_pc) begin errors++; $display("FAIL sel_out_of_range: got %h want %h", pc, exp_pc); end
    endtask

    task automatic test_reset_abort();
        exc_req = 1'b1; exc_code = 2'd2;
        tick();
        exc_req = 1'b0;
        checks++; if (vec_addr !== 32'd255) begin errors++; $display("FAIL abort_vec_addr: got %0d want 255", vec_addr); end
        tick();
        mem_data = 8'h5C;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (pc !== RST_VEC) begin errors++; $display("FAIL abort_pc: got %h want %h", pc, RST_VEC); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (exc_taken !== 1'b0) begin errors++; $display("FAIL abort_exc_taken: got %b want 0", exc_taken); end
        checks++; if (epc !== 32'h0) begin errors++; $display("FAIL abort_epc: got %h want 0", epc); end
        tick();
        checks++; if (exc_taken !== 1'b0) begin errors++; $display("FAIL abort_no_pulse: got %b want 0", exc_taken); end
        checks++; if (pc !== RST_VEC) begin errors++; $display("FAIL abort_pc_kept: got %h want %h", pc, RST_VEC); end
    endtask

    task automatic test_align();
        sel = 3'd0; set_src(0, 32'h0000_0010); pc_write = 1'b1;
        tick();
        sel = 3'd1; set_src(1, 32'h0000_0022);
        tick();
        pc_write = 1'b0;
        mem_data = 8'h30;
`ifdef PC_ALIGN_CHECK_EN
        checks++; if (epc !== 32'h10) begin errors++; $display("FAIL align_epc: got %h want 10", epc); end
        checks++; if (vec_addr !== 32'd256) begin errors++; $display("FAIL align_vec_addr: got %0d want 256", vec_addr); end
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL align_pc_hold: got %h want 10", pc); end
        exp_q.push_back(32'h0000_0030);
        tick(); tick(); tick();
`else
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL align_busy: got %b want 0", busy); end
        exp_q.push_back(32'h0000_0022);
`endif
        exp_pc = exp_q.pop_front();
        checks++; if (pc !== exp_pc) begin errors++; $display("FAIL align_pc: got %h want %h", pc, exp_pc); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] epc_before;
        epc_before = epc;
        for (int i = 0; i < NSRC; i++) set_src(i, 32'h1000 + 32'(i) * 32'h44);
        pc_write = 1'b1;
        for (int i = 0; i < NSRC; i++) begin
            sel = SEL_W'(NSRC - 1 - i);
            exp_q.push_back(32'h1000 + 32'(NSRC - 1 - i) * 32'h44);
            tick();
            exp_pc = exp_q.pop_front();
            checks++; if (pc !== exp_pc) begin errors++; $display("FAIL b2b_pc%0d: got %h want %h", i, pc, exp_pc); end
        end
        pc_write = 1'b0;
        checks++; if (epc !== epc_before) begin errors++; $display("FAIL b2b_epc: got %h want %h", epc, epc_before); end
    endtask

    initial begin
        reset = 1'b0; sel = '0; src_flat = '0;
        pc_write = 1'b0; pc_write_cond = 1'b0; cond = 1'b0;
        exc_req = 1'b0; exc_code = 2'd0; mem_data = 8'h00;
        #1;
        test_reset();
        test_sel_load();
        test_cond_load();
        test_exception();
        test_out_of_range();
        test_reset_abort();
        test_align();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pc_select_unit
`default_nettype wire

// File: doc/pc_select_unit.md
PC_SELECT_UNIT -- requirements
Module: pc_select_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, PC/source data width.
REQ-002 SHALL have parameter NSRC, default 5, number of next-PC sources (>=2).
REQ-003 SHALL have parameter RESET_VEC, default 0, PC value after reset.
REQ-004 SHALL have parameter VEC_BASE, default 253, address of first exception-vector byte.
REQ-005 SHALL define SEL_W = clog2(NSRC), minimum 1.
REQ-006 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port sel, input, SEL_W, next-PC source select.
REQ-009 SHALL have port src_flat, input, NSRC*WIDTH, source i at bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have ports pc_write, pc_write_cond, cond, each input, 1: unconditional load, conditional load, branch condition.
REQ-011 SHALL have port exc_req, input, 1, exception request.
REQ-012 SHALL have port exc_code, input, 2, exception cause.
REQ-013 SHALL have port mem_data, input, 8, vector byte returned by memory.
REQ-014 SHALL have ports pc and epc, each output, WIDTH: current PC and saved exception PC.
REQ-015 SHALL have ports vec_addr, output, WIDTH, and vec_rd, output, 1: vector-fetch request.
REQ-016 SHALL have ports busy and exc_taken, each output, 1.

Function
REQ-017 SHALL select target = src i when sel==i<NSRC, else all-zero.
REQ-018 SHALL define load = pc_write | (pc_write_cond & cond).
REQ-019 SHALL implement FSM states RUN, VEC_REQ, VEC_WAIT, VEC_LOAD.
REQ-020 SHALL, in RUN with load=1 and exc_req=0, register pc <= target next edge (1-cycle latency); otherwise hold pc.
REQ-021 SHALL, in RUN with exc_req=1, ignore load, register epc <= pc, latch exc_code, go to VEC_REQ.
REQ-022 SHALL, in VEC_REQ, drive vec_rd=1, vec_addr=VEC_BASE+latched code (zero-extended), go to VEC_WAIT.
REQ-023 SHALL, in VEC_WAIT, drive vec_rd=0, go to VEC_LOAD.
REQ-024 SHALL, in VEC_LOAD, register pc <= zero-extended mem_data, pulse exc_taken=1 for exactly that cycle, return to RUN.
REQ-025 SHALL drive busy=1 in every state except RUN; pc_write, pc_write_cond, exc_req ignored while busy.
REQ-026 SHALL drive vec_addr=0 whenever vec_rd=0.
REQ-027 SHALL leave epc unchanged except on exception entry.

Reset
REQ-028 SHALL, on reset=1 at a clock edge, set pc=RESET_VEC, epc=0, state=RUN, vec_rd=0, vec_addr=0, busy=0, exc_taken=0.
REQ-029 SHALL let reset abort any vector sequence in progress; reset has priority over all inputs.

Configuration
REQ-030 SHALL, with PC_ALIGN_CHECK_EN defined, treat RUN with load=1, exc_req=0, target[1:0]!=0 as an exception of code 3: pc not updated, epc <= pc, enter VEC_REQ.
REQ-031 SHALL, without PC_ALIGN_CHECK_EN, load any target value unchanged with no alignment logic.

Structure
REQ-032 SHALL place FSM state encodings, exception code constants (overflow 0, opcode 1, div-zero 2, misaligned 3) and VEC_BASE default in shared package pc_pkg.
REQ-033 SHALL instantiate one sub-module pc_src_mux (parametrised NSRC:1, zero for out-of-range sel).

Verification
REQ-034 SHALL cover: reset, then sel=2, src2=0x0000_0040, pc_write=1 -> pc=0x40 one cycle later.
REQ-035 SHALL cover: pc_write_cond=1, cond=0, sel=1, src1=0x80 -> pc unchanged; cond=1 -> pc=0x80.
REQ-036 SHALL cover: pc=0x100, exc_req=1, exc_code=1, pc_write=1 -> epc=0x100, vec_addr=254 with vec_rd for 1 cycle, mem_data=0x24 -> pc=0x24, exc_taken pulse, busy high 3 cycles.
REQ-037 SHALL cover: sel=7 with NSRC=5, pc_write=1 -> pc=0.
REQ-038 SHALL cover: reset asserted in VEC_WAIT -> pc=RESET_VEC, busy=0, no exc_taken.
REQ-039 SHALL cover (PC_ALIGN_CHECK_EN): pc=0x10, target 0x22 -> epc=0x10, vec_addr=256, pc=mem_data; without macro -> pc=0x22.
